instr_issue: RTL and testbench

- Stage directly upstream of the controller FSM.
- Buffers 16-bit instructions in a small FIFO and decodes the head entry into opcode/op/shift/register/immediate fields.
- Sends one start pulse per instruction to the controller, then holds the fields stable until the controller returns to waiting.
- Muxes the register number onto the datapath read/write address using the controller's reg_sel. Drops illegal encodings so the controller never deadlocks.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_issue.sv | 174 +++++++++++++++++
 tb/tb_instr_issue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issue stage: opcode/op encodings,
// issue FSM states, reg_sel encodings, decoded-field struct and decode helpers.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SEL_RM = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_RN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_EXEC
    } issue_state_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  alu_op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [1:0]  shift_op;
        logic [2:0]  rm;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } decoded_t;

    function automatic decoded_t decode(input logic [15:0] w);
        decoded_t d;
        d.opcode   = w[15:13];
        d.alu_op   = w[12:11];
        d.rn       = w[10:8];
        d.rd       = w[7:5];
        d.shift_op = w[4:3];
        d.rm       = w[2:0];
        d.sximm8   = {{8{w[7]}}, w[7:0]};
        d.sximm5   = {{11{w[4]}}, w[4:0]};
        return d;
    endfunction

    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        logic ok;
        case (opcode)
            OPC_MOV: ok = (op == OP_MOV_IMM) || (op == OP_MOV_REG);
            OPC_ALU: ok = (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND) || (op == OP_MVN);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small instruction FIFO with wrap-bit pointers; head is read combinationally
// so decoded fields are available in the same cycle the entry becomes head.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             full;
    logic             push;
    logic             do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign do_pop   = pop && !empty;
    assign head     = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Issue stage: buffers instructions, decodes the head, hands them one at a time
// to the controller. ISSUE_TIMEOUT_EN adds the ACK watchdog with re-issue.
module instr_issue
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        start,
    output logic [2:0]  opcode,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift_op,
    input  logic        waiting,
    input  logic [1:0]  reg_sel,
    output logic [2:0]  reg_num,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        illegal,
    output logic [7:0]  retired
);

    if (ACK_TIMEOUT < 2) begin : g_bad_ack_timeout
        $error("instr_issue: ACK_TIMEOUT must be at least 2");
    end

    logic [15:0]  head;
    logic         empty;
    logic         pop;
    logic         drop;
    logic         retire;
    decoded_t     dec;
    issue_state_t state_reg;
    issue_state_t state_next;
    logic         illegal_reg;
    logic [7:0]   retired_reg;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_instr),
        .in_ready (in_ready),
        .pop      (pop),
        .empty    (empty),
        .head     (head)
    );

    assign dec      = decode(head);
    assign opcode   = dec.opcode;
    assign ALU_op   = dec.alu_op;
    assign shift_op = dec.shift_op;
    assign sximm8   = dec.sximm8;
    assign sximm5   = dec.sximm5;
    assign illegal  = illegal_reg;
    assign retired  = retired_reg;

    always_comb begin
        case (reg_sel)
            SEL_RM:  reg_num = dec.rm;
            SEL_RD:  reg_num = dec.rd;
            SEL_RN:  reg_num = dec.rn;
            default: reg_num = 3'd0;
        endcase
    end

`ifdef ISSUE_TIMEOUT_EN
    // Start cycle counts as the first cycle of the window, so ACK itself
    // lasts ACK_TIMEOUT-1 cycles and starts repeat every ACK_TIMEOUT cycles.
    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 2);

    logic [CW-1:0] ack_cnt_reg;
    logic [CW-1:0] ack_cnt_next;
    logic [1:0]    retry_reg;
    logic [1:0]    retry_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt_reg <= '0;
            retry_reg   <= '0;
        end else begin
            ack_cnt_reg <= ack_cnt_next;
            retry_reg   <= retry_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        drop       = 1'b0;
        retire     = 1'b0;
        start      = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
        ack_cnt_next = ack_cnt_reg;
        retry_next   = retry_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
`ifdef ISSUE_TIMEOUT_EN
                retry_next = 2'd0;
`endif
                if (!empty && waiting) begin
                    if (is_legal(dec.opcode, dec.alu_op)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                start      = 1'b1;
                state_next = ST_ACK;
`ifdef ISSUE_TIMEOUT_EN
                ack_cnt_next = '0;
`endif
            end
            ST_ACK: begin
                if (!waiting) begin
                    state_next = ST_EXEC;
                end
`ifdef ISSUE_TIMEOUT_EN
                else if (ack_cnt_reg == ACK_LAST) begin
                    if (retry_reg == 2'd3) begin
                        pop        = 1'b1;
                        drop       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        retry_next = retry_reg + 2'd1;
                        state_next = ST_ISSUE;
                    end
                end else begin
                    ack_cnt_next = ack_cnt_reg + CW'(1);
                end
`endif
            end
            ST_EXEC: begin
                // Controller is back to waiting: its writeback is done this cycle.
                if (waiting) begin
                    pop        = 1'b1;
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            illegal_reg <= 1'b0;
            retired_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (drop) begin
                illegal_reg <= 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios plus random rounds,
// compared against a queue-based model of what the controller should see.
module tb_instr_issue;

    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic [1:0]  shift_op;
    logic        waiting;
    logic [1:0]  reg_sel;
    logic [2:0]  reg_num;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic        illegal;
    logic [7:0]  retired;

    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];
    int exp_retired = 0;
    int exp_illegal = 0;
    int legal_tops[6] = '{'h1A, 'h18, 'h14, 'h15, 'h16, 'h17};

    instr_issue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .start    (start),
        .opcode   (opcode),
        .ALU_op   (ALU_op),
        .shift_op (shift_op),
        .waiting  (waiting),
        .reg_sel  (reg_sel),
        .reg_num  (reg_num),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: arithmetic on the whole word rather than bit-field wiring.
    function automatic int m_legal(input logic [15:0] w);
        int top = int'(w) >> 11;
        return (top == 'h1A || top == 'h18 || (top >= 'h14 && top <= 'h17)) ? 1 : 0;
    endfunction

    function automatic int m_regnum(input logic [15:0] w, input int sel);
        int x = int'(w);
        case (sel)
            0:       return x % 8;
            1:       return (x / 32) % 8;
            2:       return (x / 256) % 8;
            default: return 0;
        endcase
    endfunction

    function automatic int m_sext(input logic [15:0] w, input int bits);
        int x = int'(w) % (1 << bits);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return x & 'hFFFF;
    endfunction

    function automatic logic [15:0] rand_word();
        int top;
        if ($urandom_range(0, 1) == 1) begin
            top = legal_tops[$urandom_range(0, 5)];
            return 16'((top << 11) | int'($urandom_range(0, 'h7FF)));
        end
        return 16'($urandom);
    endfunction

    // All tasks begin and end at a falling edge.
    task automatic push_word(input logic [15:0] w);
        check("in_ready", 32'(in_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
        if (q.size() < DEPTH) q.push_back(w);
        in_valid = 1'b1;
        in_instr = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic service_one();
        logic [15:0] w;
        int cnt = 0;
        int d1;
        int d2;
        int s;
        w = q.pop_front();
        while (start !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("start_seen", 32'(start), 32'd1);
        if (start !== 1'b1) return;
        check("opcode", 32'(opcode), 32'((int'(w) >> 13) % 8));
        check("ALU_op", 32'(ALU_op), 32'((int'(w) >> 11) % 4));
        check("shift_op", 32'(shift_op), 32'((int'(w) >> 3) % 4));
        check("sximm8", 32'(sximm8), 32'(m_sext(w, 8)));
        check("sximm5", 32'(sximm5), 32'(m_sext(w, 5)));
        check("illegal_at_start", 32'(illegal), 32'(exp_illegal));
        check("retired_at_start", 32'(retired), 32'(exp_retired));
        for (int i = 0; i < 4; i++) begin
            reg_sel = 2'(i);
            #1;
            check("reg_num", 32'(reg_num), 32'(m_regnum(w, i)));
        end
        d1 = int'($urandom_range(1, 3));
        repeat (d1) begin
            @(negedge clk);
            check("start_single", 32'(start), 32'd0);
        end
        waiting = 1'b0;
        d2 = int'($urandom_range(1, 4));
        repeat (d2) begin
            @(negedge clk);
            s = int'($urandom_range(0, 3));
            reg_sel = 2'(s);
            #1;
            check("reg_num_hold", 32'(reg_num), 32'(m_regnum(w, s)));
            check("sximm8_hold", 32'(sximm8), 32'(m_sext(w, 8)));
            check("start_exec", 32'(start), 32'd0);
        end
        waiting = 1'b1;
        @(negedge clk);
        exp_retired = (exp_retired + 1) % 256;
        check("retired", 32'(retired), 32'(exp_retired));
    endtask

    task automatic service_all();
        while (q.size() > 0) begin
            if (m_legal(q[0]) == 0) begin
                void'(q.pop_front());
                exp_illegal = 1;
            end else begin
                service_one();
            end
        end
        repeat (DEPTH + 2) @(negedge clk);
        check("illegal_after", 32'(illegal), 32'(exp_illegal));
        check("retired_after", 32'(retired), 32'(exp_retired));
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("start_idle", 32'(start), 32'd0);
    endtask

    task automatic random_round();
        int n;
        waiting = 1'b0;
        n = int'($urandom_range(1, DEPTH + 1));
        for (int k = 0; k < n; k++) push_word(rand_word());
        waiting = 1'b1;
        service_all();
    endtask

    initial begin
        logic [15:0] w5;
        int cnt;
        int seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0;
        waiting  = 1'b1;
        reg_sel  = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // MOV R0,#7 then ADD R2,R1,R0
        push_word(16'hD007);
        service_all();
        push_word(16'hA140);
        service_all();

        // Illegal word ahead of a legal one
        waiting = 1'b0;
        push_word(16'h0000);
        push_word(16'hA902);
        waiting = 1'b1;
        check("illegal_before_drop", 32'(illegal), 32'd0);
        @(negedge clk);
        check("illegal_after_drop", 32'(illegal), 32'd1);
        check("no_start_on_drop", 32'(start), 32'd0);
        void'(q.pop_front());
        exp_illegal = 1;
        service_all();

        // Fill the FIFO, offer a fifth word, accepted only after the first retire
        waiting = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_word(16'(('h14 << 11) | int'($urandom_range(0, 'h7FF))));
        w5 = 16'hB8E5;
        in_valid = 1'b1;
        in_instr = w5;
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("full_hold", 32'(in_ready), 32'd0);
        waiting = 1'b1;
        service_one();
        check("ready_after_retire", 32'(in_ready), 32'd1);
        q.push_back(w5);
        @(negedge clk);
        in_valid = 1'b0;
        service_all();

        // Reset while in EXEC with three entries still queued
        waiting = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_word(16'(('h18 << 11) | int'($urandom_range(0, 'h7FF))));
        waiting = 1'b1;
        cnt = 0;
        while (start !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_test_start", 32'(start), 32'd1);
        waiting = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_retired", 32'(retired), 32'd0);
        check("mid_rst_illegal", 32'(illegal), 32'd0);
        q.delete();
        exp_retired = 0;
        exp_illegal = 0;
        waiting = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (start === 1'b1) seen++;
        end
        check("empty_no_start", 32'(seen), 32'd0);

        for (int r = 0; r < 10; r++) random_round();

`ifdef ISSUE_TIMEOUT_EN
        begin
            int starts = 0;
            int last = 0;
            waiting = 1'b1;
            push_word(16'hD123);
            for (int c = 0; c < 4 * ACK_TIMEOUT + 10; c++) begin
                if (start === 1'b1) begin
                    if (starts > 0) check("start_interval", 32'(c - last), 32'(ACK_TIMEOUT));
                    last = c;
                    starts++;
                end
                @(negedge clk);
            end
            void'(q.pop_front());
            exp_illegal = 1;
            check("timeout_starts", 32'(starts), 32'd4);
            check("timeout_illegal", 32'(illegal), 32'd1);
            check("timeout_retired", 32'(retired), 32'(exp_retired));
            check("timeout_in_ready", 32'(in_ready), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
